// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive phase/dwell checker for traffic light controller outputs
module traffic_light_monitor #(
    parameter int MIN_YELLOW     = 3,
    parameter int MAX_FARM_GREEN = 10,
    parameter int DWELL_W        = 16,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         light_highway,
    input  logic [2:0]         light_farm,
    input  logic               sensor,
    input  logic               err_clr,
    output logic [2:0]         phase,
    output logic [DWELL_W-1:0] dwell,
    output logic [CNT_W-1:0]   cycle_count,
    output logic               err_code,
    output logic               err_conflict,
    output logic               err_seq,
    output logic               err_short_yellow,
    output logic               err_long_green,
    output logic               err_no_req,
    output logic               err_any
);

    typedef enum logic [2:0] {
        UNSYNC = 3'd0,
        HG     = 3'd1,
        HY     = 3'd2,
        FG     = 3'd3,
        FY     = 3'd4
    } phase_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    phase_t             state;
    phase_t             pat;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_nxt;
    logic               req_seen;
    logic               is_conflict;
    logic               is_legal;
    logic               leaving;
    logic               allowed;
    logic [5:0]         ev_vec;
    logic [5:0]         flags_q;
    logic [5:0]         flags_nxt;

    always_comb begin
        pat         = UNSYNC;
        is_conflict = (light_highway != RED) && (light_farm != RED);
        if (light_highway == GRN && light_farm == RED)      pat = HG;
        else if (light_highway == YEL && light_farm == RED) pat = HY;
        else if (light_highway == RED && light_farm == GRN) pat = FG;
        else if (light_highway == RED && light_farm == YEL) pat = FY;
        is_legal = (pat != UNSYNC);
    end

    always_comb begin
        leaving = (state != UNSYNC) && (!is_legal || pat != state);
        allowed = (state == HG && pat == HY) || (state == HY && pat == FG) ||
                  (state == FG && pat == FY) || (state == FY && pat == HG);

        if (!is_legal)                           dwell_nxt = '0;
        else if (state == UNSYNC || pat != state) dwell_nxt = DWELL_W'(1);
        else if (&dwell_q)                       dwell_nxt = dwell_q;
        else                                     dwell_nxt = dwell_q + DWELL_W'(1);

        // Bit order: code, conflict, seq, short_yellow, long_green, no_req
        ev_vec    = '0;
        ev_vec[5] = !is_legal && !is_conflict;
        ev_vec[4] = is_conflict;
        ev_vec[3] = is_legal && leaving && !allowed;
        ev_vec[2] = leaving && (state == HY || state == FY) &&
                    (dwell_q < DWELL_W'(MIN_YELLOW));
        ev_vec[1] = is_legal && state == FG && pat == FG &&
                    (dwell_nxt == DWELL_W'(MAX_FARM_GREEN + 1));
        ev_vec[0] = state == HG && pat == HY && !req_seen;

        // A same-edge event beats err_clr
        flags_nxt = (err_clr ? 6'b0 : flags_q) | ev_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= UNSYNC;
            dwell_q     <= '0;
            cycle_count <= '0;
            req_seen    <= 1'b0;
            flags_q     <= '0;
            err_any     <= 1'b0;
        end else begin
            state   <= is_legal ? pat : UNSYNC;
            dwell_q <= dwell_nxt;
            if (state == FY && pat == HG)
                cycle_count <= cycle_count + CNT_W'(1);
            if (is_legal && pat == HG) begin
                if (state != HG)
                    req_seen <= sensor;
                else if (sensor)
                    req_seen <= 1'b1;
            end
            flags_q <= flags_nxt;
            err_any <= |flags_nxt;
        end
    end

    assign phase            = state;
    assign dwell            = dwell_q;
    assign err_code         = flags_q[5];
    assign err_conflict     = flags_q[4];
    assign err_seq          = flags_q[3];
    assign err_short_yellow = flags_q[2];
    assign err_long_green   = flags_q[1];
    assign err_no_req       = flags_q[0];

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed vector table plus randomized reference-model check
module tb_traffic_light_monitor;

    localparam int MIN_Y   = 3;
    localparam int MAX_FG  = 10;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  light_highway;
    logic [2:0]  light_farm;
    logic        sensor;
    logic        err_clr;
    logic [2:0]  phase;
    logic [15:0] dwell;
    logic [7:0]  cycle_count;
    logic        err_code, err_conflict, err_seq, err_short_yellow;
    logic        err_long_green, err_no_req, err_any;

    traffic_light_monitor dut (
        .clk(clk), .rst(rst),
        .light_highway(light_highway), .light_farm(light_farm),
        .sensor(sensor), .err_clr(err_clr),
        .phase(phase), .dwell(dwell), .cycle_count(cycle_count),
        .err_code(err_code), .err_conflict(err_conflict), .err_seq(err_seq),
        .err_short_yellow(err_short_yellow), .err_long_green(err_long_green),
        .err_no_req(err_no_req), .err_any(err_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit [2:0] h;
        bit [2:0] f;
        bit       s;
        bit       c;
        bit [2:0] ph;
        int       dw;
        int       cc;
        bit [5:0] err;   // code, conflict, seq, short, long, no_req
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state
    int       m_phase, m_dwell, m_cc;
    bit       m_req;
    bit [5:0] m_flags;

    function automatic void add(bit r, bit [2:0] h, bit [2:0] f, bit s, bit c,
                                bit [2:0] ph, int dw, int cc, bit [5:0] err);
        vec_t v;
        v.rst = r; v.h = h; v.f = f; v.s = s; v.c = c;
        v.ph = ph; v.dw = dw; v.cc = cc; v.err = err;
        vecs.push_back(v);
    endfunction

    function automatic logic [33:0] act_pack();
        return {phase, dwell, cycle_count, err_any, err_code, err_conflict, err_seq,
                err_short_yellow, err_long_green, err_no_req};
    endfunction

    function automatic logic [33:0] exp_pack(int ph, int dw, int cc, bit [5:0] err);
        return {3'(ph), 16'(dw), 8'(cc), |err, err};
    endfunction

    task automatic check(string name, logic [33:0] act, logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ph/dw/cc/any/err=%h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(bit r, bit [2:0] h, bit [2:0] f, bit s, bit c);
        rst = r; light_highway = h; light_farm = f; sensor = s; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    // 1..4 = HG,HY,FG,FY; -1 conflict; -2 bad code
    function automatic int classify(bit [2:0] h, bit [2:0] f);
        if (h != R && f != R) return -1;
        if (h == G && f == R) return 1;
        if (h == Y && f == R) return 2;
        if (h == R && f == G) return 3;
        if (h == R && f == Y) return 4;
        return -2;
    endfunction

    function automatic void model_step(bit r, bit [2:0] h, bit [2:0] f, bit s, bit c);
        int p;
        bit [5:0] ev;
        if (r) begin
            m_phase = 0; m_dwell = 0; m_cc = 0; m_req = 0; m_flags = 0;
            return;
        end
        p  = classify(h, f);
        ev = 0;
        if (p < 0) begin
            if ((m_phase == 2 || m_phase == 4) && m_dwell < MIN_Y) ev[2] = 1;
            if (p == -1) ev[4] = 1; else ev[5] = 1;
            m_phase = 0; m_dwell = 0;
        end else if (m_phase == 0) begin
            m_phase = p; m_dwell = 1;
            if (p == 1) m_req = s;
        end else if (p == m_phase) begin
            m_dwell = (m_dwell < 65535) ? m_dwell + 1 : 65535;
            if (p == 3 && m_dwell == MAX_FG + 1) ev[1] = 1;
            if (p == 1 && s) m_req = 1;
        end else begin
            if (p != (m_phase % 4) + 1) ev[3] = 1;
            if ((m_phase == 2 || m_phase == 4) && m_dwell < MIN_Y) ev[2] = 1;
            if (m_phase == 1 && p == 2 && !m_req) ev[0] = 1;
            if (m_phase == 4 && p == 1) m_cc = (m_cc + 1) % 256;
            m_phase = p; m_dwell = 1;
            if (p == 1) m_req = s;
        end
        m_flags = (c ? 6'b0 : m_flags) | ev;
    endfunction

    function automatic void encode(int p, output bit [2:0] h, output bit [2:0] f);
        case (p)
            1: begin h = G; f = R; end
            2: begin h = Y; f = R; end
            3: begin h = R; f = G; end
            default: begin h = R; f = Y; end
        endcase
    endfunction

    initial begin
        rst = 1; light_highway = R; light_farm = R; sensor = 0; err_clr = 0;

        // Full legal cycle
        add(1, R, R, 0, 0, 0, 0, 0, 6'b000000);
        for (int i = 1; i <= 5; i++)  add(0, G, R, 1, 0, 1, i, 0, 6'b0);
        for (int i = 1; i <= 3; i++)  add(0, Y, R, 0, 0, 2, i, 0, 6'b0);
        for (int i = 1; i <= 10; i++) add(0, R, G, 0, 0, 3, i, 0, 6'b0);
        for (int i = 1; i <= 3; i++)  add(0, R, Y, 0, 0, 4, i, 0, 6'b0);
        add(0, G, R, 0, 0, 1, 1, 1, 6'b0);
        // Yield with no request
        add(1, R, R, 0, 0, 0, 0, 0, 6'b0);
        for (int i = 1; i <= 3; i++) add(0, G, R, 0, 0, 1, i, 0, 6'b0);
        add(0, Y, R, 0, 0, 2, 1, 0, 6'b000001);
        add(0, Y, R, 0, 0, 2, 2, 0, 6'b000001);
        // Short yellow
        add(1, R, R, 0, 0, 0, 0, 0, 6'b0);
        add(0, G, R, 1, 0, 1, 1, 0, 6'b0);
        add(0, G, R, 1, 0, 1, 2, 0, 6'b0);
        add(0, Y, R, 0, 0, 2, 1, 0, 6'b0);
        add(0, Y, R, 0, 0, 2, 2, 0, 6'b0);
        add(0, R, G, 0, 0, 3, 1, 0, 6'b000100);
        // Long farm green, then clear while still in FG
        add(1, R, R, 0, 0, 0, 0, 0, 6'b0);
        for (int i = 1; i <= 10; i++) add(0, R, G, 0, 0, 3, i, 0, 6'b0);
        add(0, R, G, 0, 0, 3, 11, 0, 6'b000010);
        add(0, R, G, 0, 1, 3, 12, 0, 6'b000000);
        add(0, R, G, 0, 0, 3, 13, 0, 6'b000000);
        // Conflict, resync, bad code, short yellow into conflict
        add(1, R, R, 0, 0, 0, 0, 0, 6'b0);
        add(0, G, G, 0, 0, 0, 0, 0, 6'b010000);
        add(0, Y, R, 0, 0, 2, 1, 0, 6'b010000);
        add(0, Y, R, 0, 0, 2, 2, 0, 6'b010000);
        add(0, Y, R, 0, 0, 2, 3, 0, 6'b010000);
        add(0, R, R, 0, 0, 0, 0, 0, 6'b110000);
        add(0, Y, R, 0, 0, 2, 1, 0, 6'b110000);
        add(0, G, G, 0, 0, 0, 0, 0, 6'b110100);
        // Sequence errors, clear vs same-edge event
        add(1, R, R, 0, 0, 0, 0, 0, 6'b0);
        add(0, G, R, 1, 0, 1, 1, 0, 6'b0);
        add(0, G, R, 1, 0, 1, 2, 0, 6'b0);
        add(0, R, G, 0, 0, 3, 1, 0, 6'b001000);
        add(0, R, G, 0, 1, 3, 2, 0, 6'b000000);
        add(1, R, R, 0, 0, 0, 0, 0, 6'b0);
        add(0, G, R, 1, 0, 1, 1, 0, 6'b0);
        add(0, R, Y, 0, 1, 4, 1, 0, 6'b001000);
        add(0, R, Y, 0, 0, 4, 2, 0, 6'b001000);
        add(0, G, R, 1, 0, 1, 1, 1, 6'b001100);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].h, vecs[i].f, vecs[i].s, vecs[i].c);
            check($sformatf("vec[%0d]", i), act_pack(),
                  exp_pack(vecs[i].ph, vecs[i].dw, vecs[i].cc, vecs[i].err));
        end

        // Randomized run against the reference model
        begin
            int gp;
            bit [2:0] h, f;
            bit r, s, c;
            gp = 1;
            apply(1, R, R, 0, 0);
            model_step(1, R, R, 0, 0);
            for (int n = 0; n < 4000; n++) begin
                int pick;
                pick = $urandom_range(0, 99);
                r = ($urandom_range(0, 299) == 0);
                c = ($urandom_range(0, 19) == 0);
                s = ($urandom_range(0, 3) == 0);
                if (pick < 78) begin
                    encode(gp, h, f);
                end else if (pick < 92) begin
                    gp = (gp % 4) + 1;
                    encode(gp, h, f);
                end else if (pick < 96) begin
                    gp = $urandom_range(1, 4);
                    encode(gp, h, f);
                end else begin
                    h = 3'($urandom_range(0, 7));
                    f = 3'($urandom_range(0, 7));
                end
                apply(r, h, f, s, c);
                model_step(r, h, f, s, c);
                check($sformatf("rand[%0d]", n), act_pack(),
                      exp_pack(m_phase, m_dwell, m_cc, m_flags));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker sitting on the traffic controller's output side.
- Samples light_highway, light_farm and the car sensor every clock, tracks the signalling phase, and counts dwell time in each phase.
- Raises sticky error flags for:
  - illegal light codes;
  - conflicting greens;
  - out-of-order phase transitions;
  - short yellows;
  - over-long farm green;
  - yielding the highway with no car request.
- Used in benches and optionally synthesized alongside the controller as a safety watchdog.

Parameters:
- MIN_YELLOW, 3, minimum cycles a yellow phase must be held.
- MAX_FARM_GREEN, 10, maximum cycles farm-road green may be held.
- DWELL_W, 16, width of the dwell counter (saturating).
- CNT_W, 8, width of the completed-cycle counter (wrapping).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- light_highway  input  3  highway light code: 3'b100 red, 3'b010 yellow, 3'b001 green.
- light_farm  input  3  farm-road light code, same encoding.
- sensor  input  1  farm-road car-present sensor (the controller's C input).
- err_clr  input  1  synchronous clear of all sticky error flags.
- phase  output  3  0 UNSYNC, 1 HG (hwy G / farm R), 2 HY, 3 FG (hwy R / farm G), 4 FY.
- dwell  output  DWELL_W  cycles the current phase has been held, including the current cycle.
- cycle_count  output  CNT_W  completed full FY->HG cycles.
- err_code  output  1  sticky: illegal light code or illegal pair.
- err_conflict  output  1  sticky: neither light red.
- err_seq  output  1  sticky: illegal phase transition.
- err_short_yellow  output  1  sticky: yellow left with dwell < MIN_YELLOW.
- err_long_green  output  1  sticky: FG dwell exceeded MAX_FARM_GREEN.
- err_no_req  output  1  sticky: HG->HY with no sensor request seen.
- err_any  output  1  OR of all err_* flags (registered).

Behaviour:
- Reset values:
  - phase=0 (UNSYNC), dwell=0, cycle_count=0, all err_*=0.
  - The internal request latch req_seen is cleared.
- Latency: outputs reflect inputs sampled at edge N and are valid after edge N (1 cycle).
- Pattern decode each edge:
  - Legal pairs are (G,R)=HG, (Y,R)=HY, (R,G)=FG, (R,Y)=FY.
  - Neither light red -> conflict event only (err_code not set).
  - Any other code (including R,R or a non-one-hot value) -> code event.
  - On either event: phase goes to UNSYNC, dwell=0.
- Resync: from UNSYNC, the first legal pattern loads that phase with dwell=1. No transition, dwell or request checks are applied on a resync.
- Same legal pattern as the current phase: dwell increments, saturating at all-ones.
- New legal pattern:
  - Allowed transitions are HG->HY, HY->FG, FG->FY and FY->HG.
  - Any other legal->legal change raises a seq event. phase still follows the input and dwell=1.
- Short yellow: on leaving HY or FY (to any pattern) with registered dwell < MIN_YELLOW, raise a short_yellow event.
- Long green: in FG, the first cycle dwell becomes MAX_FARM_GREEN+1 raises a long_green event. It fires once per FG phase.
- Request latch:
  - Set on any edge where the sampled pattern is HG and sensor=1.
  - Cleared on every entry into HG, including resync.
  - On an HG->HY transition the registered req_seen is checked (the sensor value on the transition edge is not counted). If 0, raise a no_req event.
- cycle_count increments on each legal FY->HG transition and wraps modulo 2^CNT_W.
- Sticky flags:
  - An event sets its flag.
  - err_clr clears all flags.
  - If an event and err_clr occur on the same edge, the event wins and the flag is set.
  - err_clr does not affect phase, dwell or cycle_count.
- Reset mid-operation: returns everything to reset values on that edge. The next legal pattern resyncs without checks.

Test Plan:
1. Reset, then drive HG with sensor=1 for 5 cycles, HY 3, FG 10, FY 3, back to HG. Expect phase sequence 1,2,3,4,1; cycle_count=1; all err_*=0.
2. HG with sensor=0 throughout, then HY. Expect err_no_req=1 one cycle after the HY sample; err_any=1.
3. HY held only 2 cycles then FG, with MIN_YELLOW=3. Expect err_short_yellow=1; phase=3.
4. FG held 11 cycles. Expect err_long_green to rise after the 11th FG edge and stay 1. Assert err_clr while FG continues at dwell 12 and expect the flag to clear (no second event).
5. Drive hwy=3'b001, farm=3'b001 (both green). Expect err_conflict=1, err_code=0, phase=0. Then drive HY and expect a resync to phase=2 with dwell=1 and no err_seq.
6. Go HG->FG directly. Expect err_seq=1. Assert err_clr on the same edge as an HG->FY seq event and expect err_seq to remain 1.
